serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop.
- Accepts two parallel operands and a carry-in on a start pulse, then adds one bit per clock, LSB first.
- Presents the parallel sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits downstream of the combinational full-adder stage: it is the sequential consumer that reuses one FA cell across time. It is the area-optimised alternative to the ripple adder.

---
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit
// operands LSB first, one bit per clock, then present sum/cout/ovf with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             c_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] acc_next;

  // The single full-adder cell shared across all bit positions.
  always_comb begin
    s_bit    = sa_reg[0] ^ sb_reg[0] ^ c_reg;
    c_next   = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & c_reg) | (sb_reg[0] & c_reg);
    acc_next = {s_bit, acc_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      sa_reg    <= '0;
      sb_reg    <= '0;
      acc_reg   <= '0;
      c_reg     <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            c_reg     <= cin;
            cnt_reg   <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          acc_reg <= acc_next;
          c_reg   <= c_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            // On the MSB edge c_reg is exactly the carry into the MSB.
            state_reg <= S_DONE;
            sum_reg   <= acc_next;
            cout_reg  <= c_next;
            ovf_reg   <= c_reg ^ c_next;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected results are queued at start
// and compared, with latency, whenever the adder raises done.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cycle   = 0;
  int   n_start = 0;
  int   n_done  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a_in),
    .b    (b_in),
    .cin  (cin_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("spurious_done", n_done, n_start);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
        check("latency", cycle, e.due);
        $display("txn %0d sum=%h cout=%b ovf=%b cycle=%0d", n_done, sum, cout, ovf, cycle);
      end
    end
  end

  // Called at a negedge while the adder is idle; returns one negedge later.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input bit push);
    logic [WIDTH:0] t;
    exp_t e;
    a_in   = ta;
    b_in   = tb;
    cin_in = tc;
    start  = 1'b1;
    if (push) begin
      t      = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
      e.sum  = t[WIDTH-1:0];
      e.cout = t[WIDTH];
      e.ovf  = (ta[WIDTH-1] == tb[WIDTH-1]) && (t[WIDTH-1] != ta[WIDTH-1]);
      e.due  = cycle + 1 + WIDTH;
      sb_q.push_back(e);
      n_start++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles up to and including done, then steps into the idle cycle.
  task automatic wait_done(output int busy_cnt);
    bit got;
    got      = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("done_timeout", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int bc;
    rst    = 1'b1;
    start  = 1'b1;
    a_in   = 8'hFF;
    b_in   = 8'hFF;
    cin_in = 1'b1;

    // Reset held with start asserted.
    repeat (2) @(negedge clk);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Basic add with busy-length check.
    start_op(8'h3C, 8'h25, 1'b0, 1'b1);
    wait_done(bc);
    check("busy_cycles", bc, WIDTH + 1);
    check("after_done_busy", busy, 1'b0);
    check("after_done_done", done, 1'b0);

    // Carry-out and signed-overflow corners.
    start_op(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done(bc);
    start_op(8'h7F, 8'h00, 1'b1, 1'b1);
    wait_done(bc);

    // Start while busy must be ignored.
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    repeat (2 * WIDTH) @(negedge clk);
    check("hold_sum", sum, 8'h30);
    check("ignored_start_busy", busy, 1'b0);

    // Reset on the 4th RUN edge aborts and clears results.
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_done", done, 1'b0);
    repeat (2 * WIDTH) @(negedge clk);
    start_op(8'hA5, 8'h5A, 1'b1, 1'b1);
    wait_done(bc);

    // Back-to-back random regression.
    for (int i = 0; i < 1000; i++) begin
      start_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_done(bc);
    end

    repeat (4) @(negedge clk);
    check("start_done_count", n_done, n_start);
    check("queue_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
